conv_encoder: RTL
=================

CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 Parameter G0, default 7'o171, generator polynomial for output bit 0; bit 6 taps the current input bit.
REQ-002 Parameter G1, default 7'o133, generator polynomial for output bit 1; bit 6 taps the current input bit.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 RSTn  input  1  asynchronous active-low reset.
REQ-005 d_in_valid  input  1  information bit present on d_in.
REQ-006 d_in  input  1  information bit.
REQ-007 d_in_last  input  1  qualifies d_in as the final bit of a frame.
REQ-008 d_in_ready  output  1  encoder accepts a bit this cycle.
REQ-009 d_out_valid  output  1  coded symbol present on d_out; same valid-only protocol that viterbi_decoder consumes, no backpressure.
REQ-010 d_out  output  2  coded symbol: [0] = G0 parity, [1] = G1 parity.
REQ-011 d_out_last  output  1  marks the final symbol of a frame.

Function
REQ-012 A bit is accepted when d_in_valid and d_in_ready are both 1 at a rising edge.
REQ-013 The encoder is rate 1/2, constraint length 7: window w[6:0] = {current bit, previous bits t-1 .. t-6}, with w[0] = bit t-6.
REQ-014 Parity: d_out[0] = XOR-reduce(w & G0), d_out[1] = XOR-reduce(w & G1).
REQ-015 Outputs are registered: the symbol for an accepted bit appears exactly 1 cycle after acceptance, with d_out_valid = 1 for exactly that cycle.
REQ-016 d_out_valid is 0 in every cycle that follows a cycle with no acceptance and no tail emission.
REQ-017 The state machine has two states: DATA (d_in_ready = 1) and TAIL (d_in_ready = 0).
REQ-018 DATA to TAIL occurs on acceptance with d_in_last = 1 when CONV_ENCODER_TAIL_EN is defined.
REQ-019 In TAIL, exactly 6 zero bits are shifted in, one per cycle, with a 3-bit counter running 0..5; the counter does not wrap.
REQ-020 TAIL emits one symbol per cycle: 6 consecutive valid symbols directly following the last-bit symbol.
REQ-021 d_out_last = 1 only on the 6th tail symbol; TAIL then returns to DATA with the shift register all zero.
REQ-022 d_in_valid asserted during TAIL is ignored: no acceptance and no state change.
REQ-023 Back-to-back frames are legal; the first bit of the next frame is accepted in the cycle after the 6th tail bit.
REQ-024 A frame of length 1 (d_in_last on the first bit) is legal.

Reset
REQ-025 RSTn = 0 forces immediately: d_out_valid = 0, d_out = 2'b00, d_out_last = 0, shift register = 0, state = DATA, tail counter = 0.
REQ-026 d_in_ready = 1 while in reset and after reset release.
REQ-027 Reset asserted mid-frame or mid-tail aborts the frame with no further symbols emitted; the next accepted bit starts a new frame from the zero state.

Configuration
REQ-028 Macro CONV_ENCODER_TAIL_EN defined: tail termination per REQ-018 to REQ-021.
REQ-029 Macro not defined: TAIL state and counter are absent and d_in_ready is constant 1.
REQ-030 Macro not defined: d_out_last = 1 on the symbol of the d_in_last bit, and the shift register clears to zero on that acceptance (truncated frame).

Structure
REQ-031 Shared package conv_pkg holds: constraint length K = 7, memory depth K-1 = 6, default generators 7'o171 and 7'o133, and the state enum {DATA, TAIL}.
REQ-032 The package is shared with viterbi_decoder.
REQ-033 Sub-module conv_parity (combinational: window plus generator in, parity bit out) is instantiated twice, once per output bit.

Verification
REQ-034 All-zero frame of 10 bits, TAIL_EN defined -> 16 symbols all 2'b00; d_out_last on the 16th; d_in_ready = 0 for exactly 6 cycles.
REQ-035 Impulse: single bit 1 with d_in_last, TAIL_EN defined -> d_out sequence 11, 01, 11, 11, 00, 10, 11 on consecutive cycles; d_out_last on the 7th only.
REQ-036 Same impulse, TAIL_EN undefined -> one symbol 2'b11 with d_out_last = 1; the following frame's bit 0 encodes as 2'b00.
REQ-037 d_in_valid held at 1 through the tail -> bits offered while d_in_ready = 0 are not consumed; the next frame's first symbol appears 1 cycle after ready rises.
REQ-038 RSTn pulsed low during tail symbol 3 -> all outputs 0 asynchronously; no d_out_last; a subsequent impulse frame reproduces the REQ-035 sequence.
REQ-039 Loopback: 628 random bits encoded and fed to viterbi_decoder -> decoded bits equal the source bits with 0 errors.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the rate-1/2, K=7 convolutional code.
// Used by conv_encoder and by viterbi_decoder, so both ends of the link
// agree on constraint length, generators and the frame state encoding.
package conv_pkg;

    // Constraint length and the encoder memory depth (bits of history kept)
    localparam int K   = 7;
    localparam int MEM = K - 1;

    // Industry-standard generators (octal 171 / 133); bit K-1 taps the current bit
    localparam logic [K-1:0] G0_DEFAULT = 7'o171;
    localparam logic [K-1:0] G1_DEFAULT = 7'o133;

    // Tail flushing shifts MEM zero bits; the counter stops at MEM-1
    localparam int           TAIL_CNT_W = 3;
    localparam logic [TAIL_CNT_W-1:0] TAIL_LAST = TAIL_CNT_W'(MEM - 1);

    // Frame state of the encoder
    typedef enum logic {
        DATA = 1'b0,
        TAIL = 1'b1
    } enc_state_e;

    // Parity of a code window against one generator polynomial
    function automatic logic gen_parity(input logic [K-1:0] window,
                                        input logic [K-1:0] gen);
        return ^(window & gen);
    endfunction

endpackage

// File: rtl/conv_parity.sv
// One output bit of the convolutional code: XOR of the window bits
// selected by a generator polynomial. Purely combinational.
module conv_parity
    import conv_pkg::*;
(
    input  logic [K-1:0] window,
    input  logic [K-1:0] gen,
    output logic         parity
);

    // Tapped-bit XOR reduction
    always_comb begin
        parity = gen_parity(window, gen);
    end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2, constraint-length-7 convolutional encoder with registered outputs.
//
// Optional feature: define CONV_ENCODER_TAIL_EN to terminate every frame with
// six zero tail bits (trellis returns to the zero state). Without it the frame
// is truncated: the shift register clears on the last bit and d_in_ready is
// always 1.
//
// State table (only present with CONV_ENCODER_TAIL_EN):
//   state | meaning
//   DATA  | accepting information bits, d_in_ready = 1
//   TAIL  | shifting in 6 zero bits, one symbol per cycle, d_in_ready = 0
module conv_encoder
    import conv_pkg::*;
#(
    parameter logic [K-1:0] G0 = G0_DEFAULT,
    parameter logic [K-1:0] G1 = G1_DEFAULT
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       d_in_valid,
    input  logic       d_in,
    input  logic       d_in_last,
    output logic       d_in_ready,
    output logic       d_out_valid,
    output logic [1:0] d_out,
    output logic       d_out_last
);

    // shift_q[MEM-1] is bit t-1, shift_q[0] is bit t-6
    logic [MEM-1:0] shift_q;
    logic [K-1:0]   window;
    logic [1:0]     parity;

    // Per-cycle controls derived from the frame state
    logic           in_bit;     // bit entering the window this cycle
    logic           shift_en;   // a symbol is produced this cycle
    logic           frame_end;  // that symbol closes the frame
    logic           clear_sr;   // truncate: reset history instead of shifting

`ifdef CONV_ENCODER_TAIL_EN
    enc_state_e            state_q,    state_d;
    logic [TAIL_CNT_W-1:0] tail_cnt_q, tail_cnt_d;

    // State and tail counter registers
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= DATA;
            tail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tail_cnt_q <= tail_cnt_d;
        end
    end

    // Next-state: enter TAIL on the last bit, leave after the 6th tail bit
    always_comb begin
        state_d    = state_q;
        tail_cnt_d = tail_cnt_q;
        case (state_q)
            DATA: begin
                if (d_in_valid && d_in_last) begin
                    state_d    = TAIL;
                    tail_cnt_d = '0;
                end
            end
            TAIL: begin
                if (tail_cnt_q == TAIL_LAST) begin
                    state_d    = DATA;
                    tail_cnt_d = '0;
                end else begin
                    tail_cnt_d = tail_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = DATA;
                tail_cnt_d = '0;
            end
        endcase
    end

    // State outputs: zeros are fed during TAIL and input is ignored there
    always_comb begin
        d_in_ready = (state_q == DATA);
        in_bit     = (state_q == DATA) ? d_in : 1'b0;
        shift_en   = (state_q == TAIL) || d_in_valid;
        frame_end  = (state_q == TAIL) && (tail_cnt_q == TAIL_LAST);
        clear_sr   = 1'b0;
    end
`else
    // Truncated frames: always ready, history dropped on the last bit
    always_comb begin
        d_in_ready = 1'b1;
        in_bit     = d_in;
        shift_en   = d_in_valid;
        frame_end  = d_in_valid && d_in_last;
        clear_sr   = d_in_valid && d_in_last;
    end
`endif

    assign window = {in_bit, shift_q};

    conv_parity u_parity0 (
        .window (window),
        .gen    (G0),
        .parity (parity[0])
    );

    conv_parity u_parity1 (
        .window (window),
        .gen    (G1),
        .parity (parity[1])
    );

    // Encoder memory: shift the new bit in, or clear at a truncated frame end
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            shift_q <= '0;
        end else if (shift_en) begin
            if (clear_sr) begin
                shift_q <= '0;
            end else begin
                shift_q <= {in_bit, shift_q[MEM-1:1]};
            end
        end
    end

    // Registered symbol output, valid for exactly the cycle after production
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            d_out_valid <= 1'b0;
            d_out       <= 2'b00;
            d_out_last  <= 1'b0;
        end else begin
            d_out_valid <= shift_en;
            d_out       <= shift_en ? parity : 2'b00;
            d_out_last  <= shift_en && frame_end;
        end
    end

endmodule
